// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio output stage.
package audio_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } gain_state_t;

  localparam int              GAIN_W   = 4;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 4'd15;
  localparam int              LEVEL_W  = 8;

endpackage

// File: rtl/audio_strobe_div.sv
// audio_strobe_div: fractional divider producing a one-cycle strobe at
// SAMPLE_RATE on average from a CLK_FREQ clock (phase accumulator).
module audio_strobe_div #(
  parameter int CLK_FREQ    = 25175000,
  parameter int SAMPLE_RATE = 16384
) (
  input  logic clock,
  input  logic reset_n,
  output logic strobe_o
);

  // acc < CLK_FREQ and SAMPLE_RATE < CLK_FREQ, so the sum stays below
  // 2*CLK_FREQ and fits one extra bit above clog2(CLK_FREQ).
  localparam int               ACC_W = $clog2(CLK_FREQ) + 1;
  localparam logic [ACC_W-1:0] FREQ  = ACC_W'(CLK_FREQ);
  localparam logic [ACC_W-1:0] RATE  = ACC_W'(SAMPLE_RATE);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  assign sum = acc + RATE;

  // Advance the phase; emit a strobe and subtract one period on overflow.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc      <= '0;
      strobe_o <= 1'b0;
    end else if (sum >= FREQ) begin
      acc      <= sum - FREQ;
      strobe_o <= 1'b1;
    end else begin
      acc      <= sum;
      strobe_o <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_out.sv
// audio_out: sample strobe generation, click-free mute/unmute gain ramp and
// 1-bit audio output. Build option AUDIO_PWM_EN replaces the sigma-delta
// modulator with a glitch-free 8-bit PWM.
module audio_out #(
  parameter int CLK_FREQ    = 25175000,
  parameter int SAMPLE_RATE = 16384,
  parameter int RAMP_DIV    = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] sample_i,
  input  logic       mute_i,
  output logic       sample_ena_o,
  output logic [3:0] gain_o,
  output logic       muted_o,
  output logic       audio_o
);

  import audio_pkg::*;

  localparam int              CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  gain_state_t         state, state_nx;
  logic [GAIN_W-1:0]   gain, gain_nx;
  logic [CNT_W-1:0]    ramp_cnt, cnt_nx, cnt_tick;
  logic                wrap;
  logic [3:0]          sample_p0;
  logic [LEVEL_W-1:0]  level_mult;
  logic [LEVEL_W-1:0]  level_p1;

  // Saturating single gain step; never wraps past 0 or GAIN_MAX.
  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] g,
                                                  input logic up);
    if (up) return (g == GAIN_MAX) ? g : g + 1'b1;
    else    return (g == '0)       ? g : g - 1'b1;
  endfunction

  audio_strobe_div #(
    .CLK_FREQ   (CLK_FREQ),
    .SAMPLE_RATE(SAMPLE_RATE)
  ) u_strobe (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe_o(sample_ena_o)
  );

  // Stage p0: capture the generator sample once per strobe.
  always_ff @(posedge clock) begin
    if (!reset_n)          sample_p0 <= '0;
    else if (sample_ena_o) sample_p0 <= sample_i;
  end

  // Gain FSM state register; only moves on strobe cycles via state_nx.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= MUTED;
      gain     <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_nx;
      gain     <= gain_nx;
      ramp_cnt <= cnt_nx;
    end
  end

  // Gain FSM next state: ramp one step every RAMP_DIV strobes; a reversal
  // keeps the current gain and restarts the step interval.
  always_comb begin
    state_nx = state;
    gain_nx  = gain;
    cnt_nx   = ramp_cnt;
    wrap     = (ramp_cnt == CNT_LAST);
    cnt_tick = wrap ? '0 : ramp_cnt + 1'b1;
    if (sample_ena_o) begin
      unique case (state)
        MUTED: begin
          gain_nx = '0;
          cnt_nx  = '0;
          if (!mute_i) begin
            // The unmute strobe already counts toward the first step.
            state_nx = RAMP_UP;
            cnt_nx   = cnt_tick;
            if (wrap) gain_nx = gain_step('0, 1'b1);
          end
        end
        RAMP_UP: begin
          if (mute_i) begin
            state_nx = RAMP_DOWN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_tick;
            if (wrap) gain_nx = gain_step(gain, 1'b1);
            if (gain_nx == GAIN_MAX) begin
              state_nx = PLAY;
              cnt_nx   = '0;
            end
          end
        end
        PLAY: begin
          gain_nx = GAIN_MAX;
          cnt_nx  = '0;
          if (mute_i) state_nx = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (!mute_i) begin
            state_nx = RAMP_UP;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_tick;
            if (wrap) gain_nx = gain_step(gain, 1'b0);
            if (gain_nx == '0) begin
              state_nx = MUTED;
              cnt_nx   = '0;
            end
          end
        end
        default: begin
          state_nx = MUTED;
          gain_nx  = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign gain_o     = gain;
  assign muted_o    = (state == MUTED);
  assign level_mult = {4'b0000, sample_p0} * {4'b0000, gain};

`ifdef AUDIO_PWM_EN
  logic [LEVEL_W-1:0] pwm_cnt;

  // Stage p1 + PWM: level reloads only at the end of a PWM period.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      level_p1 <= '0;
      audio_o  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) level_p1 <= level_mult;
      audio_o <= (pwm_cnt < level_p1);
    end
  end
`else
  logic [LEVEL_W-1:0] dacc;
  logic [LEVEL_W:0]   dsum;

  assign dsum = {1'b0, dacc} + {1'b0, level_p1};

  // Stage p1: register the scaled level every cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) level_p1 <= '0;
    else          level_p1 <= level_mult;
  end

  // First-order sigma-delta: the accumulator carry is the output bit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dacc    <= '0;
      audio_o <= 1'b0;
    end else begin
      dacc    <= dsum[LEVEL_W-1:0];
      audio_o <= dsum[LEVEL_W];
    end
  end
`endif

endmodule

// File: tb/tb_audio_out.sv
// tb_audio_out: directed bench for audio_out with a strobe-driven scoreboard
// for the gain ramp and direct checks for strobe timing, density and reset.
module tb_audio_out;

  localparam int CLK_FREQ    = 16;
  localparam int SAMPLE_RATE = 4;
  localparam int RAMP_DIV    = 2;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sample_i = 4'd0;
  logic       mute_i  = 1'b1;
  logic       sample_ena_o;
  logic [3:0] gain_o;
  logic       muted_o;
  logic       audio_o;
  logic       strobe10;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  typedef struct {
    logic [3:0] gain;
    logic       muted;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  audio_out #(
    .CLK_FREQ   (CLK_FREQ),
    .SAMPLE_RATE(SAMPLE_RATE),
    .RAMP_DIV   (RAMP_DIV)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample_i    (sample_i),
    .mute_i      (mute_i),
    .sample_ena_o(sample_ena_o),
    .gain_o      (gain_o),
    .muted_o     (muted_o),
    .audio_o     (audio_o)
  );

  audio_strobe_div #(
    .CLK_FREQ   (10),
    .SAMPLE_RATE(4)
  ) u_div10 (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe_o(strobe10)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gain(input int g, input int budget);
    int c;
    c = 0;
    while (int'(gain_o) != g && c < budget) begin
      step();
      c++;
    end
    check("wait_gain", int'(gain_o), g);
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (audio_o) ones++;
    end
  endtask

  // Monitor: after every strobe edge compare gain/muted with the next expectation.
  initial begin : monitor
    exp_t e;
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          strobes++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("gain_strobe%0d", strobes), int'(gain_o), int'(e.gain));
            check($sformatf("muted_strobe%0d", strobes), int'(muted_o), int'(e.muted));
          end
        end
        pend = sample_ena_o;
      end
    end
  end

  // Stimulus
  initial begin : stim
    logic [20:1] exp10;
    int ones;
    exp10 = 20'b1010_0101_0010_1001_0100;

    // Reset state
    mute_i   = 1'b0;
    sample_i = 4'd15;
    reset_n  = 1'b0;
    repeat (3) step();
    check("rst_gain", int'(gain_o), 0);
    check("rst_muted", int'(muted_o), 1);
    check("rst_audio", int'(audio_o), 0);
    check("rst_ena", int'(sample_ena_o), 0);

    // Unmute ramp: gain k/2 after strobe k, PLAY from strobe 30
    for (int k = 1; k <= 30; k++) exp_q.push_back('{gain: 4'(k / 2), muted: 1'b0});
    exp_q.push_back('{gain: 4'd15, muted: 1'b0});
    exp_q.push_back('{gain: 4'd15, muted: 1'b0});
    reset_n = 1'b1;

    // Strobe timing for 16/4 and 10/4 dividers
    for (int c = 1; c <= 20; c++) begin
      step();
      check($sformatf("ena16_c%0d", c), int'(sample_ena_o), int'(c % 4 == 0));
      check($sformatf("ena10_c%0d", c), int'(strobe10), int'(exp10[c]));
      if (c == 4) check("muted_before_strobe", int'(muted_o), 1);
      if (c == 5) check("muted_after_strobe", int'(muted_o), 0);
    end
    wait_drain(300);

    // Density at full gain for several sample values
    check("play_gain", int'(gain_o), 15);
    repeat (300) step();
    count_ones(256, ones);
    check("density_225", ones, 225);
    sample_i = 4'd4;
    repeat (300) step();
    count_ones(256, ones);
    check("density_60", ones, 60);
    sample_i = 4'd8;
    repeat (300) step();
    count_ones(256, ones);
    check("density_120", ones, 120);
    sample_i = 4'd0;
    repeat (300) step();
    count_ones(256, ones);
    check("density_0", ones, 0);

    // Reset pulse during PLAY with audio toggling
    sample_i = 4'd15;
    repeat (300) step();
    count_ones(16, ones);
    check("toggling_before_reset", int'(ones > 0 && ones < 16), 1);
    exp_q.delete();
    reset_n = 1'b0;
    step();
    check("midrst_gain", int'(gain_o), 0);
    check("midrst_muted", int'(muted_o), 1);
    check("midrst_audio", int'(audio_o), 0);
    check("midrst_ena", int'(sample_ena_o), 0);

    // Reversal at gain 7 during RAMP_UP; muted 14 strobes after reversal
    for (int k = 1; k <= 14; k++) exp_q.push_back('{gain: 4'(k / 2), muted: 1'b0});
    for (int j = 0; j <= 14; j++) exp_q.push_back('{gain: 4'(7 - j / 2), muted: (j == 14)});
    exp_q.push_back('{gain: 4'd0, muted: 1'b1});
    reset_n = 1'b1;
    wait_gain(7, 200);
    mute_i = 1'b1;
    wait_drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
